// File: rtl/mux4_reg.sv
// 4-to-1 steering mux with a combinational output and an enable-gated registered copy.
// Define MUX4_REG_PARITY_EN to add z_par, the registered XOR-reduction of z_q.
module mux4_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q,
    output logic [1:0]       sel_q
`ifdef MUX4_REG_PARITY_EN
    ,
    output logic             z_par
`endif
);

    logic [WIDTH-1:0] z_q_reg;
    logic [WIDTH-1:0] z_q_next;
    logic [1:0]       sel_q_reg;
    logic [1:0]       sel_q_next;

    // An unknown select must show up as X on z rather than quietly picking d0.
    always_comb begin
        z = 'x;
        case (sel)
            2'b00:   z = d0;
            2'b01:   z = d1;
            2'b10:   z = d2;
            2'b11:   z = d3;
            default: z = 'x;
        endcase
    end

    always_comb begin
        z_q_next   = z_q_reg;
        sel_q_next = sel_q_reg;
        if (en) begin
            z_q_next   = z;
            sel_q_next = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q_reg   <= '0;
            sel_q_reg <= 2'b00;
        end else begin
            z_q_reg   <= z_q_next;
            sel_q_reg <= sel_q_next;
        end
    end

    assign z_q   = z_q_reg;
    assign sel_q = sel_q_reg;

`ifdef MUX4_REG_PARITY_EN
    logic z_par_reg;
    logic z_par_next;

    // Parity is computed from the captured data so it is aligned with z_q on every cycle.
    always_comb begin
        z_par_next = z_par_reg;
        if (en) begin
            z_par_next = ^z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_par_reg <= 1'b0;
        end else begin
            z_par_reg <= z_par_next;
        end
    end

    assign z_par = z_par_reg;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// Directed bench for mux4_reg: a WIDTH=1 and a WIDTH=8 instance share clk and rst.
module tb_mux4_reg;

    logic       clk = 1'b0;
    logic       rst;

    logic       a0, a1, a2, a3;
    logic [1:0] asel;
    logic       aen;
    logic       az, az_q;
    logic [1:0] asel_q;

    logic [7:0] b0, b1, b2, b3;
    logic [1:0] bsel;
    logic       ben;
    logic [7:0] bz, bz_q;
    logic [1:0] bsel_q;

    int checks = 0;
    int errors = 0;

`ifdef MUX4_REG_PARITY_EN
    logic       az_par, bz_par;
`endif

    always #5 clk = ~clk;

    mux4_reg #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst   (rst),
        .d0    (a0),
        .d1    (a1),
        .d2    (a2),
        .d3    (a3),
        .sel   (asel),
        .en    (aen),
        .z     (az),
        .z_q   (az_q),
        .sel_q (asel_q)
`ifdef MUX4_REG_PARITY_EN
        ,
        .z_par (az_par)
`endif
    );

    mux4_reg #(.WIDTH(8)) u_w8 (
        .clk   (clk),
        .rst   (rst),
        .d0    (b0),
        .d1    (b1),
        .d2    (b2),
        .d3    (b3),
        .sel   (bsel),
        .en    (ben),
        .z     (bz),
        .z_q   (bz_q),
        .sel_q (bsel_q)
`ifdef MUX4_REG_PARITY_EN
        ,
        .z_par (bz_par)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8 [4];
        exp8[0] = 8'h11;
        exp8[1] = 8'h22;
        exp8[2] = 8'h33;
        exp8[3] = 8'h44;

        rst  = 1'b1;
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b1; a3 = 1'b1;
        asel = 2'b00; aen = 1'b0;
        b0 = 8'h11; b1 = 8'h22; b2 = 8'h33; b3 = 8'h44;
        bsel = 2'b00; ben = 1'b0;
        #2;
        chk("rst_az_q", 64'(az_q), 64'd0);
        chk("rst_asel_q", 64'(asel_q), 64'd0);
        chk("rst_bz_q", 64'(bz_q), 64'd0);
        chk("rst_az_follows", 64'(az), 64'd0);
        chk("rst_bz_follows", 64'(bz), 64'h11);

        @(negedge clk);
        rst = 1'b0;

        // sel=00 held for 32 time units, z stays 0
        for (int i = 0; i < 4; i++) begin
            #8;
            chk("w1_sel0_hold", 64'(az), 64'd0);
        end

        // sel=10: z updates without any clock
        asel = 2'b10;
        #1;
        chk("w1_sel2_comb", 64'(az), 64'd1);
        chk("w1_sel2_noedge_zq", 64'(az_q), 64'd0);
        aen = 1'b1;
        tick();
        chk("w1_sel2_zq", 64'(az_q), 64'd1);
        chk("w1_sel2_selq", 64'(asel_q), 64'd2);

        asel = 2'b00;
        #1;
        chk("w1_sel0_comb", 64'(az), 64'd0);
        chk("w1_sel0_zq_before", 64'(az_q), 64'd1);
        tick();
        chk("w1_sel0_zq", 64'(az_q), 64'd0);
        chk("w1_sel0_selq", 64'(asel_q), 64'd0);
        aen = 1'b0;

        // WIDTH=8 sweep of all select codes
        ben = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bsel = 2'(s);
            #1;
            chk("w8_sweep_z", 64'(bz), 64'(exp8[s]));
            tick();
            chk("w8_sweep_zq", 64'(bz_q), 64'(exp8[s]));
            chk("w8_sweep_selq", 64'(bsel_q), 64'(s));
        end

        // en=0 holds z_q/sel_q even though the input changes
        ben  = 1'b0;
        bsel = 2'b01;
        tick();
        chk("w8_hold_zq", 64'(bz_q), 64'h44);
        chk("w8_hold_selq", 64'(bsel_q), 64'd3);
        bsel = 2'b11;

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("w8_arst_zq", 64'(bz_q), 64'd0);
        chk("w8_arst_selq", 64'(bsel_q), 64'd0);
        chk("w8_arst_z", 64'(bz), 64'h44);
        @(negedge clk);
        rst = 1'b0;
        ben = 1'b0;
        tick();
        chk("w8_post_rst_hold1", 64'(bz_q), 64'd0);
        tick();
        chk("w8_post_rst_hold2", 64'(bz_q), 64'd0);
        ben = 1'b1;
        tick();
        chk("w8_post_rst_cap", 64'(bz_q), 64'h44);
        chk("w8_post_rst_selq", 64'(bsel_q), 64'd3);

`ifdef MUX4_REG_PARITY_EN
        bsel = 2'b00;
        b0   = 8'h07;
        tick();
        chk("par_07", 64'(bz_par), 64'd1);
        chk("par_07_zq", 64'(bz_q), 64'h07);
        b0 = 8'h03;
        tick();
        chk("par_03", 64'(bz_par), 64'd0);
        b0 = 8'h07;
        tick();
        chk("par_07_again", 64'(bz_par), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("par_rst", 64'(bz_par), 64'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
